sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Two-requester arbiter and access sequencer for the single external SRAM port of the SLC-3. It shares the SRAM between the CPU memory path (MAR/MDR driven by the ISDU) and a debug/program-loader port. It serialises their accesses and produces the active-low OE/WE strobes with a programmable access time. The block sits between the requesters and the SRAM pins, replacing direct drive of ADDR/OE/WE by the CPU.

## Interface
Parameters:
- WAIT_CYCLES, default 2: cycles OE/WE stay asserted per access; legal range 1..15.

Ports:
- Clk  in  1  system clock; all state on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held until cpu_ready.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  16  CPU word address.
- cpu_wdata  in  16  CPU write data.
- cpu_rdata  out  16  read data returned to CPU (MDR_In source).
- cpu_ready  out  1  one-cycle completion pulse.
- dbg_req, dbg_we, dbg_addr[15:0], dbg_wdata[15:0]  in  debug port, same meaning as the CPU inputs.
- dbg_rdata  out  16, dbg_ready  out  1: debug port, same meaning as the CPU outputs.
- gnt_cpu, gnt_dbg  out  1 each  current owner; at most one is high.
- ADDR  out  16  SRAM address.
- Data_to_SRAM  out  16  SRAM write data.
- Data_from_SRAM  in  16  SRAM read data.
- OE  out  1  active-low output enable.
- WE  out  1  active-low write enable.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE:
  - OE=WE=1 and no grant.
  - If any req is high at the edge, select the winner, latch its we/addr/wdata into internal registers, set its gnt, load the wait counter with WAIT_CYCLES-1, and go to ACCESS.
- ACCESS:
  - ADDR and Data_to_SRAM are driven from the latched registers.
  - Read: OE=0, WE=1. Write: WE=0, OE=1.
  - The counter decrements each cycle. At the edge ending the cycle with counter==0, go to DONE.
  - For a read, that same edge captures Data_from_SRAM into the winner's rdata register.
- DONE:
  - OE=WE=1; ADDR and Data_to_SRAM are held (address/data hold time).
  - The winner's ready is 1 for this cycle only; gnt stays high.
  - Next state is always IDLE.
- rdata registers hold their value until the next read by the same port. A write never changes rdata.
- Handshake:
  - The requester holds req, we, addr and wdata stable from assertion through its ready cycle.
  - A req still high in the cycle after ready is a new request.
  - Deasserting req mid-transaction has no effect; the latched transaction completes and ready still pulses.
- Arbitration: see Configuration. The losing request stays pending; it is never dropped.
- Reset asserted at any time (including mid-write):
  - Immediately: state IDLE, OE=1, WE=1, ADDR=0, Data_to_SRAM=0, cpu_rdata=dbg_rdata=0, ready=0, gnt=0, counter=0, round-robin pointer=dbg (CPU wins the first tie).
  - An interrupted write leaves SRAM content undefined at that address.

## Timing
- req is high before edge k and the port wins. Then:
  - ACCESS spans cycles k..k+W-1 (W = WAIT_CYCLES).
  - DONE is cycle k+W.
  - IDLE is cycle k+W+1.
- Latency from the granting edge to ready is W cycles. Throughput is one access per W+2 cycles.
- The minimum gap of one IDLE cycle between accesses is mandatory, even with the same requester.
- OE/WE never assert in the same cycle. The strobes change only on Clk edges, except for the asynchronous reset deassertion.
- ADDR is stable for W+1 cycles, the whole ACCESS plus DONE window.

## Configuration
- Macro: SRAM_ARB_ROUND_ROBIN_EN.
- Defined (round robin):
  - On simultaneous requests in IDLE, grant the port that was not granted last; the pointer updates at each grant.
  - A single requester is always granted.
  - Each port is guaranteed service within one competing transaction.
- Undefined (fixed priority):
  - CPU always wins ties; no pointer register.
  - The debug port may starve while cpu_req stays high.

## Test plan
- Reset values: with Reset=0, check ADDR=0x0000, OE=1, WE=1, both ready=0, both gnt=0. Release Reset, hold all req=0 for 10 cycles, and check OE/WE stay 1.
- CPU read, W=2:
  - Stimulus: cpu_req=1, cpu_we=0, cpu_addr=0x0012; SRAM returns 0xBEEF.
  - Response: OE=0 for exactly 2 cycles, then cpu_ready pulses for 1 cycle with cpu_rdata=0xBEEF, and ADDR=0x0012 throughout.
- Debug write:
  - Stimulus: dbg_req=1, dbg_we=1, dbg_addr=0x3000, dbg_wdata=0x1234.
  - Response: WE=0 for W cycles with Data_to_SRAM=0x1234 and OE=1, then dbg_ready=1. dbg_rdata is unchanged.
- Simultaneous requests, both held for 3 transactions:
  - With the macro: grants go CPU, DBG, CPU.
  - Without the macro: grants go CPU, CPU, CPU, with dbg_ready never pulsing.
- Reset mid-write: assert Reset in the 2nd ACCESS cycle with W=3. WE=1 and OE=1 immediately, with no ready pulse. After release, a fresh CPU request completes normally.
- Back-to-back, W=1: cpu_req held high for 2 reads (0x0001, then 0x0002). The ready pulses are exactly 3 cycles apart, with one IDLE cycle showing OE=1 between the accesses.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//
// Shares the single external SRAM port between the CPU memory path and a
// debug/program-loader port. One access is sequenced at a time:
//   IDLE -> ACCESS (WAIT_CYCLES cycles, OE or WE low) -> DONE (strobes high,
//   address/data held, ready pulse) -> IDLE.
// Throughput is one access per WAIT_CYCLES+2 cycles.
//
// Configuration:
//   SRAM_ARB_ROUND_ROBIN_EN defined   : round-robin tie break (CPU wins first tie)
//   SRAM_ARB_ROUND_ROBIN_EN undefined : fixed priority, CPU always wins ties
//
// Parameters:
//   WAIT_CYCLES    strobe-active cycles per access, 1..15
//
// Ports:
//   Clk, Reset                  clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata       CPU request (held until cpu_ready)
//   cpu_rdata, cpu_ready        CPU read data and one-cycle completion pulse
//   dbg_req/we/addr/wdata       debug request (held until dbg_ready)
//   dbg_rdata, dbg_ready        debug read data and one-cycle completion pulse
//   gnt_cpu, gnt_dbg            current owner, mutually exclusive
//   ADDR, Data_to_SRAM          SRAM address and write data
//   Data_from_SRAM              SRAM read data
//   OE, WE                      active-low SRAM strobes (registered)
module sram_port_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [15:0] dbg_addr,
  input  logic [15:0] dbg_wdata,
  output logic [15:0] dbg_rdata,
  output logic        dbg_ready,
  output logic        gnt_cpu,
  output logic        gnt_dbg,
  output logic [15:0] ADDR,
  output logic [15:0] Data_to_SRAM,
  input  logic [15:0] Data_from_SRAM,
  output logic        OE,
  output logic        WE
);

  localparam logic [3:0] CntLoad = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        own_dbg_q, own_dbg_d;   // 1 = debug port owns the current access
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] cpu_rdata_q, cpu_rdata_d;
  logic [15:0] dbg_rdata_q, dbg_rdata_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        win_dbg;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  // Last granted port; resets to debug so the CPU wins the first tie.
  logic        last_dbg_q, last_dbg_d;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      last_dbg_q <= 1'b1;
    end else begin
      last_dbg_q <= last_dbg_d;
    end
  end

  assign win_dbg = dbg_req & (~cpu_req | ~last_dbg_q);
`else
  assign win_dbg = dbg_req & ~cpu_req;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    own_dbg_d   = own_dbg_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    last_dbg_d  = last_dbg_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (cpu_req || dbg_req) begin
          state_d   = StAccess;
          own_dbg_d = win_dbg;
          we_d      = win_dbg ? dbg_we    : cpu_we;
          addr_d    = win_dbg ? dbg_addr  : cpu_addr;
          wdata_d   = win_dbg ? dbg_wdata : cpu_wdata;
          cnt_d     = CntLoad;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
          last_dbg_d = win_dbg;
`endif
        end
      end
      StAccess: begin
        if (cnt_q == 4'd0) begin
          state_d = StDone;
          // Read data is sampled on the edge that ends the last strobe cycle.
          if (!we_q) begin
            if (own_dbg_q) dbg_rdata_d = Data_from_SRAM;
            else           cpu_rdata_d = Data_from_SRAM;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Strobes are registered from the next state so they only move on Clk.
    oe_n_d = !((state_d == StAccess) && !we_d);
    we_n_d = !((state_d == StAccess) &&  we_d);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      own_dbg_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 16'h0000;
      wdata_q     <= 16'h0000;
      cpu_rdata_q <= 16'h0000;
      dbg_rdata_q <= 16'h0000;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      own_dbg_q   <= own_dbg_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
    end
  end

  assign gnt_cpu      = (state_q != StIdle) & ~own_dbg_q;
  assign gnt_dbg      = (state_q != StIdle) &  own_dbg_q;
  assign cpu_ready    = (state_q == StDone) & ~own_dbg_q;
  assign dbg_ready    = (state_q == StDone) &  own_dbg_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign dbg_rdata    = dbg_rdata_q;
  assign ADDR         = addr_q;
  assign Data_to_SRAM = wdata_q;
  assign OE           = oe_n_q;
  assign WE           = we_n_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter. Three instances (W=2, W=3, W=1) share
// the request inputs; each test checks the instance whose timing it targets.
module tb_sram_port_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata, sram_rd;

  logic [15:0] a_cpu_rdata, a_dbg_rdata, a_addr, a_dout;
  logic        a_cpu_ready, a_dbg_ready, a_gnt_cpu, a_gnt_dbg, a_oe, a_we;
  logic [15:0] b_cpu_rdata, b_dbg_rdata, b_addr, b_dout;
  logic        b_cpu_ready, b_dbg_ready, b_gnt_cpu, b_gnt_dbg, b_oe, b_we;
  logic [15:0] c_cpu_rdata, c_dbg_rdata, c_addr, c_dout;
  logic        c_cpu_ready, c_dbg_ready, c_gnt_cpu, c_gnt_dbg, c_oe, c_we;

  int n_vec = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  sram_port_arbiter #(.WAIT_CYCLES(2)) u_w2 (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(a_cpu_rdata), .cpu_ready(a_cpu_ready),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(a_dbg_rdata), .dbg_ready(a_dbg_ready),
    .gnt_cpu(a_gnt_cpu), .gnt_dbg(a_gnt_dbg), .ADDR(a_addr), .Data_to_SRAM(a_dout),
    .Data_from_SRAM(sram_rd), .OE(a_oe), .WE(a_we)
  );

  sram_port_arbiter #(.WAIT_CYCLES(3)) u_w3 (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(b_cpu_rdata), .cpu_ready(b_cpu_ready),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(b_dbg_rdata), .dbg_ready(b_dbg_ready),
    .gnt_cpu(b_gnt_cpu), .gnt_dbg(b_gnt_dbg), .ADDR(b_addr), .Data_to_SRAM(b_dout),
    .Data_from_SRAM(sram_rd), .OE(b_oe), .WE(b_we)
  );

  sram_port_arbiter #(.WAIT_CYCLES(1)) u_w1 (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(c_cpu_rdata), .cpu_ready(c_cpu_ready),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(c_dbg_rdata), .dbg_ready(c_dbg_ready),
    .gnt_cpu(c_gnt_cpu), .gnt_dbg(c_gnt_dbg), .ADDR(c_addr), .Data_to_SRAM(c_dout),
    .Data_from_SRAM(sram_rd), .OE(c_oe), .WE(c_we)
  );

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge Clk);
  endtask

  task automatic test_reset();
    int strobe_low;
    @(negedge Clk);
    n_vec++; if (a_addr !== 16'h0000) begin n_err++;
      $display("FAIL reset_addr got %h want 0000", a_addr); end
    n_vec++; if ({a_oe, a_we} !== 2'b11) begin n_err++;
      $display("FAIL reset_strobes got OE=%b WE=%b want 1 1", a_oe, a_we); end
    n_vec++; if ({a_cpu_ready, a_dbg_ready, a_gnt_cpu, a_gnt_dbg} !== 4'b0000) begin n_err++;
      $display("FAIL reset_ready_gnt got %b want 0000",
               {a_cpu_ready, a_dbg_ready, a_gnt_cpu, a_gnt_dbg}); end
    Reset = 1'b1;
    strobe_low = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (a_oe !== 1'b1 || a_we !== 1'b1) strobe_low++;
    end
    n_vec++; if (strobe_low !== 0) begin n_err++;
      $display("FAIL idle_strobes got %0d low cycles want 0", strobe_low); end
  endtask

  task automatic test_cpu_read();
    int oe_low = 0, addr_bad = 0, cyc = 0;
    bit seen = 0;
    @(negedge Clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0012; sram_rd = 16'hBEEF;
    while (!seen && cyc < 20) begin
      @(negedge Clk); cyc++;
      if (a_oe === 1'b0) oe_low++;
      if (a_addr !== 16'h0012) addr_bad++;
      if (a_cpu_ready === 1'b1) seen = 1;
    end
    n_vec++; if (seen !== 1'b1) begin n_err++;
      $display("FAIL cpu_read_ready got none want pulse"); end
    n_vec++; if (cyc !== 3) begin n_err++;
      $display("FAIL cpu_read_latency got %0d want 3", cyc); end
    n_vec++; if (oe_low !== 2) begin n_err++;
      $display("FAIL cpu_read_oe_cycles got %0d want 2", oe_low); end
    n_vec++; if (addr_bad !== 0) begin n_err++;
      $display("FAIL cpu_read_addr got %0d bad cycles want 0", addr_bad); end
    n_vec++; if (a_cpu_rdata !== 16'hBEEF) begin n_err++;
      $display("FAIL cpu_read_data got %h want beef", a_cpu_rdata); end
    n_vec++; if (a_gnt_cpu !== 1'b1 || a_oe !== 1'b1) begin n_err++;
      $display("FAIL cpu_read_done got gnt=%b OE=%b want 1 1", a_gnt_cpu, a_oe); end
    cpu_req = 1'b0;
    @(negedge Clk);
    n_vec++; if ({a_cpu_ready, a_gnt_cpu, a_oe} !== 3'b001) begin n_err++;
      $display("FAIL cpu_read_after got rdy/gnt/OE=%b want 001",
               {a_cpu_ready, a_gnt_cpu, a_oe}); end
    idle_cycles(6);
  endtask

  task automatic test_dbg_write();
    int we_low = 0, oe_low = 0, dout_bad = 0, cyc = 0;
    bit seen = 0;
    @(negedge Clk);
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h3000; dbg_wdata = 16'h1234;
    sram_rd = 16'hDEAD;
    while (!seen && cyc < 20) begin
      @(negedge Clk); cyc++;
      if (a_we === 1'b0) begin
        we_low++;
        if (a_dout !== 16'h1234 || a_addr !== 16'h3000) dout_bad++;
      end
      if (a_oe === 1'b0) oe_low++;
      if (a_dbg_ready === 1'b1) seen = 1;
    end
    n_vec++; if (seen !== 1'b1) begin n_err++;
      $display("FAIL dbg_write_ready got none want pulse"); end
    n_vec++; if (we_low !== 2 || oe_low !== 0) begin n_err++;
      $display("FAIL dbg_write_strobes got WE_low=%0d OE_low=%0d want 2 0", we_low, oe_low); end
    n_vec++; if (dout_bad !== 0) begin n_err++;
      $display("FAIL dbg_write_data got %0d bad cycles want 0", dout_bad); end
    n_vec++; if (a_dbg_rdata !== 16'h0000 || a_cpu_rdata !== 16'hBEEF) begin n_err++;
      $display("FAIL dbg_write_rdata got dbg=%h cpu=%h want 0000 beef",
               a_dbg_rdata, a_cpu_rdata); end
    dbg_req = 1'b0;
    idle_cycles(6);
  endtask

  task automatic test_simultaneous();
    bit seq [3];
    int n_rdy = 0, both = 0, cyc = 0;
    bit exp1;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    exp1 = 1'b1;
`else
    exp1 = 1'b0;
`endif
    Reset = 1'b0; @(negedge Clk); Reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0200; sram_rd = 16'h7777;
    while (n_rdy < 3 && cyc < 40) begin
      @(negedge Clk); cyc++;
      if (a_gnt_cpu === 1'b1 && a_gnt_dbg === 1'b1) both++;
      if (a_cpu_ready === 1'b1 || a_dbg_ready === 1'b1) begin
        seq[n_rdy] = a_dbg_ready;
        n_rdy++;
      end
    end
    n_vec++; if (n_rdy !== 3) begin n_err++;
      $display("FAIL arb_count got %0d want 3", n_rdy); end
    n_vec++; if (both !== 0) begin n_err++;
      $display("FAIL arb_both_gnt got %0d want 0", both); end
    n_vec++; if (seq[0] !== 1'b0) begin n_err++;
      $display("FAIL arb_grant0 got dbg=%b want 0", seq[0]); end
    n_vec++; if (seq[1] !== exp1) begin n_err++;
      $display("FAIL arb_grant1 got dbg=%b want %b", seq[1], exp1); end
    n_vec++; if (seq[2] !== 1'b0) begin n_err++;
      $display("FAIL arb_grant2 got dbg=%b want 0", seq[2]); end
    cpu_req = 1'b0; dbg_req = 1'b0;
    idle_cycles(8);
  endtask

  task automatic test_reset_mid_write();
    int rdy = 0, oe_low = 0, cyc = 0;
    bit seen = 0;
    @(negedge Clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0042; cpu_wdata = 16'hAAAA;
    @(negedge Clk);
    n_vec++; if (b_we !== 1'b0) begin n_err++;
      $display("FAIL midwr_access1 got WE=%b want 0", b_we); end
    @(posedge Clk); #2;
    Reset = 1'b0; #1;
    n_vec++; if ({b_we, b_oe} !== 2'b11) begin n_err++;
      $display("FAIL midwr_strobes got WE=%b OE=%b want 1 1", b_we, b_oe); end
    n_vec++; if (b_addr !== 16'h0000 || b_dout !== 16'h0000 || b_cpu_rdata !== 16'h0000)
    begin n_err++;
      $display("FAIL midwr_regs got addr=%h dout=%h rdata=%h want 0", b_addr, b_dout,
               b_cpu_rdata); end
    cpu_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      if (b_cpu_ready !== 1'b0 || b_gnt_cpu !== 1'b0) rdy++;
    end
    n_vec++; if (rdy !== 0) begin n_err++;
      $display("FAIL midwr_no_ready got %0d cycles want 0", rdy); end
    Reset = 1'b1;
    @(negedge Clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0055; sram_rd = 16'h5A5A;
    while (!seen && cyc < 20) begin
      @(negedge Clk); cyc++;
      if (b_oe === 1'b0) oe_low++;
      if (b_cpu_ready === 1'b1) seen = 1;
    end
    n_vec++; if (seen !== 1'b1 || oe_low !== 3) begin n_err++;
      $display("FAIL midwr_fresh got ready=%b OE_low=%0d want 1 3", seen, oe_low); end
    n_vec++; if (b_cpu_rdata !== 16'h5A5A) begin n_err++;
      $display("FAIL midwr_fresh_data got %h want 5a5a", b_cpu_rdata); end
    cpu_req = 1'b0;
    idle_cycles(8);
  endtask

  task automatic test_back_to_back();
    int cyc = 0, t1 = 0, oe_low = 0;
    bit seen = 0;
    @(negedge Clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0001; sram_rd = 16'h1111;
    while (!seen && cyc < 20) begin
      @(negedge Clk); cyc++;
      if (c_oe === 1'b0) oe_low++;
      if (c_cpu_ready === 1'b1) seen = 1;
    end
    t1 = cyc;
    n_vec++; if (seen !== 1'b1 || oe_low !== 1) begin n_err++;
      $display("FAIL b2b_first got ready=%b OE_low=%0d want 1 1", seen, oe_low); end
    n_vec++; if (c_cpu_rdata !== 16'h1111) begin n_err++;
      $display("FAIL b2b_data1 got %h want 1111", c_cpu_rdata); end
    @(negedge Clk); cyc++;
    n_vec++; if ({c_oe, c_cpu_ready} !== 2'b10) begin n_err++;
      $display("FAIL b2b_idle got OE/ready=%b want 10", {c_oe, c_cpu_ready}); end
    cpu_addr = 16'h0002; sram_rd = 16'h2222;
    seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge Clk); cyc++;
      if (c_cpu_ready === 1'b1) seen = 1;
    end
    n_vec++; if (seen !== 1'b1 || (cyc - t1) !== 3) begin n_err++;
      $display("FAIL b2b_gap got ready=%b gap=%0d want 1 3", seen, cyc - t1); end
    n_vec++; if (c_cpu_rdata !== 16'h2222 || c_addr !== 16'h0002) begin n_err++;
      $display("FAIL b2b_data2 got rdata=%h addr=%h want 2222 0002", c_cpu_rdata, c_addr); end
    cpu_req = 1'b0;
    idle_cycles(4);
  endtask

  initial begin
    Reset = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 16'h0; dbg_wdata = 16'h0;
    sram_rd = 16'h0;
    test_reset();
    test_cpu_read();
    test_dbg_write();
    test_simultaneous();
    test_reset_mid_write();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
